// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the frame-buffer slave state type.
// Also holds the little-endian byte-lane helper used by the write port.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } slave_state_t;

  // Byte enables for a legal (aligned) access; lane 0 is the least significant byte.
  function automatic logic [3:0] lane_enables(input logic [2:0] size, input logic [1:0] off);
    case (size)
      HSIZE_BYTE: lane_enables = 4'b0001 << off;
      HSIZE_HALF: lane_enables = off[1] ? 4'b1100 : 4'b0011;
      default:    lane_enables = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/fb_ram.sv
// Frame memory: one byte-enabled write port, one combinational read port
// for the bus, and one registered read port for display scan-out.
module fb_ram #(
  parameter int DEPTH = 1024,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [3:0]    wbe,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata,
  input  logic [AW-1:0] scan_addr,
  output logic [31:0]   scan_data
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (wbe[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Scan read samples the array before a same-edge write lands, so it sees old data.
  always_ff @(posedge clk) begin
    if (!n_rst) scan_data <= '0;
    else        scan_data <= mem[scan_addr];
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ahb_fb_slave.sv
// AHB-Lite frame-buffer responder: address decode, wait-state FSM, ERROR
// responses and byte-lane writes into fb_ram, plus an independent scan port.
module ahb_fb_slave
  import ahb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH       = 1024,
  parameter int          WAIT_STATES = 0,
  localparam int         AW          = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          HSEL,
  input  logic [31:0]   HADDR,
  input  logic [1:0]    HTRANS,
  input  logic          HWRITE,
  input  logic [2:0]    HSIZE,
  input  logic [31:0]   HWDATA,
  input  logic          HREADY,
  output logic          HREADYOUT,
  output logic          HRESP,
  output logic [31:0]   HRDATA,
  input  logic [AW-1:0] scan_addr,
  output logic [31:0]   scan_data,
  output slave_state_t  dbg_state
);

  slave_state_t  state;
  logic [AW-1:0] addr_q;
  logic [1:0]    off_q;
  logic [2:0]    size_q;
  logic          write_q;
  logic [2:0]    wait_cnt;
  logic [31:0]   hrdata_q;
  logic [31:0]   ram_rdata;

  htrans_t       trans;
  logic [32:0]   addr_ext;
  logic [32:0]   base_ext;
  logic [32:0]   top_ext;
  logic [AW-1:0] word_idx;
  logic          in_range;
  logic          aligned;
  logic          legal;
  logic          can_accept;
  logic          accept;
  logic          ram_we;

  assign trans    = htrans_t'(HTRANS);
  assign addr_ext = {1'b0, HADDR};
  assign base_ext = {1'b0, BASE_ADDR};
  assign top_ext  = base_ext + 33'(4 * DEPTH);
  assign in_range = (addr_ext >= base_ext) && (addr_ext < top_ext);
  assign word_idx = AW'((HADDR - BASE_ADDR) >> 2);

  always_comb begin
    aligned = 1'b0;
    case (HSIZE)
      HSIZE_BYTE: aligned = 1'b1;
      HSIZE_HALF: aligned = ~HADDR[0];
      HSIZE_WORD: aligned = (HADDR[1:0] == 2'b00);
      default:    aligned = 1'b0;
    endcase
  end

  assign legal = in_range && aligned;

  // Handshake: a transfer is taken when HSEL, HREADY and an active HTRANS
  // (NONSEQ/SEQ) coincide while this slave is in a ready state; a new address
  // phase may overlap the DATA or ERR2 cycle of the previous transfer.
  assign can_accept = (state == ST_IDLE) || (state == ST_DATA) || (state == ST_ERR2);
  assign accept     = can_accept && HSEL && HREADY &&
                      ((trans == HTRANS_NONSEQ) || (trans == HTRANS_SEQ));

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
      addr_q   <= '0;
      off_q    <= '0;
      size_q   <= '0;
      write_q  <= 1'b0;
      hrdata_q <= '0;
    end else begin
      if ((state == ST_DATA) && !write_q) hrdata_q <= ram_rdata;

      case (state)
        ST_WAIT: begin
          if (wait_cnt == 3'd0) state <= ST_DATA;
          else                  wait_cnt <= wait_cnt - 3'd1;
        end
        ST_ERR1: state <= ST_ERR2;
        default: state <= ST_IDLE;
      endcase

      if (accept) begin
        addr_q  <= word_idx;
        off_q   <= HADDR[1:0];
        size_q  <= HSIZE;
        write_q <= HWRITE;
        if (!legal) begin
          state <= ST_ERR1;
        end else if (WAIT_STATES > 0) begin
          state    <= ST_WAIT;
          wait_cnt <= 3'(WAIT_STATES - 1);
        end else begin
          state <= ST_DATA;
        end
      end
    end
  end

  assign HREADYOUT = !((state == ST_WAIT) || (state == ST_ERR1));
  assign HRESP     = ((state == ST_ERR1) || (state == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
  assign HRDATA    = ((state == ST_DATA) && !write_q) ? ram_rdata : hrdata_q;
  assign dbg_state = state;

  // The write lands on the edge closing DATA, so any later data phase
  // (including a pipelined read of the same word) reads the new value.
  assign ram_we = n_rst && (state == ST_DATA) && write_q;

  fb_ram #(.DEPTH(DEPTH)) u_ram (
    .clk       (clk),
    .n_rst     (n_rst),
    .we        (ram_we),
    .waddr     (addr_q),
    .wbe       (lane_enables(size_q, off_q)),
    .wdata     (HWDATA),
    .raddr     (addr_q),
    .rdata     (ram_rdata),
    .scan_addr (scan_addr),
    .scan_data (scan_data)
  );

endmodule
